// File: rtl/game_flow_ctrl_pkg.sv
// Shared types and widths for the flappy game sequencer and its display consumers.
package game_flow_ctrl_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int SCORE_W     = 2 * BCD_DIGIT_W;
    localparam int SPEED_W     = 4;

    localparam logic [SCORE_W-1:0] BCD_MAX = 8'h99;

    // Screen/phase selector, also decoded by the RGB block
    typedef enum logic [1:0] {
        MODE_ATTRACT = 2'd0,
        MODE_PLAY    = 2'd1,
        MODE_DYING   = 2'd2,
        MODE_OVER    = 2'd3
    } mode_e;

endpackage

// File: rtl/game_flow_ctrl_bcd_inc2.sv
// Two-digit BCD incrementer that holds at 99; purely combinational.
module bcd_inc2
    import game_flow_ctrl_pkg::*;
(
    input  logic [SCORE_W-1:0] i_bcd,
    output logic [SCORE_W-1:0] o_bcd
);

    logic [BCD_DIGIT_W-1:0] w_lo;
    logic [BCD_DIGIT_W-1:0] w_hi;

    assign w_lo = i_bcd[BCD_DIGIT_W-1:0];
    assign w_hi = i_bcd[SCORE_W-1:BCD_DIGIT_W];

    always_comb begin
        o_bcd = i_bcd;
        if (i_bcd == BCD_MAX) begin
            o_bcd = BCD_MAX;
        end else if (w_lo == 4'd9) begin
            o_bcd = {w_hi + 4'd1, 4'd0};
        end else begin
            o_bcd = {w_hi, w_lo + 4'd1};
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Round sequencer: attract/play/dying/over phases, BCD score, best score and speed schedule.
module game_flow_ctrl
    import game_flow_ctrl_pkg::*;
#(
    parameter int unsigned DIE_FRAMES = 60,
    parameter int unsigned OVER_LOCK  = 30,
    parameter int unsigned SPEED_MIN  = 3,
    parameter int unsigned SPEED_MAX  = 7,
    parameter int unsigned LEVEL_STEP = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_btn_start,
    input  logic               i_frame_tick,
    input  logic               i_pass,
    input  logic               i_collide,
    output logic [1:0]         o_mode,
    output logic               o_play_en,
    output logic               o_game_rst,
    output logic [SPEED_W-1:0] o_speed,
    output logic [SCORE_W-1:0] o_score_bcd,
    output logic [SCORE_W-1:0] o_best_bcd,
    output logic               o_new_best
);

    // A zero death delay still waits for one frame tick
    localparam logic [7:0]         DIE_LOAD   = (DIE_FRAMES == 0) ? 8'd1 : 8'(DIE_FRAMES);
    localparam logic [7:0]         LOCK_LOAD  = 8'(OVER_LOCK);
    localparam logic [3:0]         LEVEL_LAST = 4'(LEVEL_STEP - 1);
    localparam logic [SPEED_W-1:0] SPD_MIN    = SPEED_W'(SPEED_MIN);
    localparam logic [SPEED_W-1:0] SPD_MAX    = SPEED_W'(SPEED_MAX);

    logic               r_start_meta, r_start_sync, r_start_prev, r_pass_prev;
    mode_e              r_state;
    logic [7:0]         r_die_cnt, r_lock_cnt;
    logic [3:0]         r_level;
    logic [SPEED_W-1:0] r_speed;
    logic [SCORE_W-1:0] r_score, r_best;
    logic               r_new_best, r_game_rst, r_play_en;

    mode_e              w_state_nxt;
    logic [7:0]         w_die_nxt, w_lock_nxt;
    logic [3:0]         w_level_nxt;
    logic [SPEED_W-1:0] w_speed_nxt;
    logic [SCORE_W-1:0] w_score_nxt, w_best_nxt, w_score_inc;
    logic               w_new_best_nxt, w_game_rst_nxt, w_new_round;
    logic               w_start_evt, w_pass_evt;

    assign w_start_evt = r_start_sync & ~r_start_prev;
    assign w_pass_evt  = i_pass & ~r_pass_prev;

    bcd_inc2 u_score_inc (
        .i_bcd (r_score),
        .o_bcd (w_score_inc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start_meta <= 1'b0;
            r_start_sync <= 1'b0;
            r_start_prev <= 1'b0;
            r_pass_prev  <= 1'b0;
            r_state      <= MODE_ATTRACT;
            r_die_cnt    <= '0;
            r_lock_cnt   <= '0;
            r_level      <= '0;
            r_speed      <= SPD_MIN;
            r_score      <= '0;
            r_best       <= '0;
            r_new_best   <= 1'b0;
            r_game_rst   <= 1'b0;
            r_play_en    <= 1'b0;
        end else begin
            r_start_meta <= i_btn_start;
            r_start_sync <= r_start_meta;
            r_start_prev <= r_start_sync;
            r_pass_prev  <= i_pass;
            r_state      <= w_state_nxt;
            r_die_cnt    <= w_die_nxt;
            r_lock_cnt   <= w_lock_nxt;
            r_level      <= w_level_nxt;
            r_speed      <= w_speed_nxt;
            r_score      <= w_score_nxt;
            r_best       <= w_best_nxt;
            r_new_best   <= w_new_best_nxt;
            r_game_rst   <= w_game_rst_nxt;
            r_play_en    <= (w_state_nxt == MODE_PLAY);
        end
    end

    // Collide beats pass in PLAY; in OVER the registered lock value gates start, so a tick that empties it cannot admit the same start
    always_comb begin
        w_state_nxt    = r_state;
        w_die_nxt      = r_die_cnt;
        w_lock_nxt     = r_lock_cnt;
        w_level_nxt    = r_level;
        w_speed_nxt    = r_speed;
        w_score_nxt    = r_score;
        w_best_nxt     = r_best;
        w_new_best_nxt = r_new_best;
        w_game_rst_nxt = 1'b0;
        w_new_round    = 1'b0;
        case (r_state)
            MODE_ATTRACT: begin
                w_new_round = w_start_evt;
            end
            MODE_PLAY: begin
                if (i_collide) begin
                    w_state_nxt = MODE_DYING;
                    w_die_nxt   = DIE_LOAD;
                end else if (w_pass_evt) begin
                    w_score_nxt = w_score_inc;
                    if (r_level >= LEVEL_LAST) begin
                        w_level_nxt = '0;
                        if (r_speed < SPD_MAX) begin
                            w_speed_nxt = r_speed + 1'b1;
                        end
                    end else begin
                        w_level_nxt = r_level + 1'b1;
                    end
                end
            end
            MODE_DYING: begin
                if (r_die_cnt == '0) begin
                    w_state_nxt = MODE_OVER;
                    w_lock_nxt  = LOCK_LOAD;
                    if (r_score > r_best) begin
                        w_best_nxt     = r_score;
                        w_new_best_nxt = 1'b1;
                    end
                end else if (i_frame_tick) begin
                    w_die_nxt = r_die_cnt - 1'b1;
                end
            end
            MODE_OVER: begin
                if (i_frame_tick && (r_lock_cnt != '0)) begin
                    w_lock_nxt = r_lock_cnt - 1'b1;
                end
                w_new_round = w_start_evt && (r_lock_cnt == '0);
            end
            default: begin
                w_state_nxt = MODE_ATTRACT;
            end
        endcase
        if (w_new_round) begin
            w_state_nxt    = MODE_PLAY;
            w_game_rst_nxt = 1'b1;
            w_score_nxt    = '0;
            w_level_nxt    = '0;
            w_new_best_nxt = 1'b0;
            w_speed_nxt    = SPD_MIN;
        end
    end

    assign o_mode      = r_state;
    assign o_play_en   = r_play_en;
    assign o_game_rst  = r_game_rst;
    assign o_speed     = r_speed;
    assign o_score_bcd = r_score;
    assign o_best_bcd  = r_best;
    assign o_new_best  = r_new_best;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: vector table of pass bursts plus hand-written phase sequences.
module tb_game_flow_ctrl;
    import game_flow_ctrl_pkg::*;

    logic               clk, rst;
    logic               i_btn_start, i_frame_tick, i_pass, i_collide;
    logic [1:0]         o_mode;
    logic               o_play_en, o_game_rst, o_new_best;
    logic [SPEED_W-1:0] o_speed;
    logic [SCORE_W-1:0] o_score_bcd, o_best_bcd;

    typedef struct {
        int         nPass;
        int         hold;
        logic [7:0] expScore;
        logic [3:0] expSpeed;
    } vec_t;

    typedef struct {
        logic [7:0] score;
        logic [3:0] speed;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   modelPasses = 0;

    game_flow_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .i_btn_start (i_btn_start),
        .i_frame_tick(i_frame_tick),
        .i_pass      (i_pass),
        .i_collide   (i_collide),
        .o_mode      (o_mode),
        .o_play_en   (o_play_en),
        .o_game_rst  (o_game_rst),
        .o_speed     (o_speed),
        .o_score_bcd (o_score_bcd),
        .o_best_bcd  (o_best_bcd),
        .o_new_best  (o_new_best)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] toBcd(input int v);
        int c;
        c = (v > 99) ? 99 : v;
        return 8'(((c / 10) << 4) | (c % 10));
    endfunction

    function automatic logic [3:0] modelSpeed(input int v);
        int s;
        s = 3 + v / 5;
        return 4'((s > 7) ? 7 : s);
    endfunction

    task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One pass pulse; the model's expectation goes onto the scoreboard
    task automatic applyStimulus(input int hold);
        exp_t e;
        modelPasses++;
        e.score = toBcd(modelPasses);
        e.speed = modelSpeed(modelPasses);
        sb.push_back(e);
        i_pass = 1'b1;
        repeat (hold) @(negedge clk);
        i_pass = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic checkOutput(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            compareVal({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            compareVal({name, "_score"}, 32'(o_score_bcd), 32'(e.score));
            compareVal({name, "_speed"}, 32'(o_speed), 32'(e.speed));
        end
    endtask

    task automatic runVectors(input int first, input int last, input string tag);
        for (int v = first; v <= last; v++) begin
            for (int p = 0; p < vecs[v].nPass; p++) begin
                applyStimulus(vecs[v].hold);
                checkOutput($sformatf("%s_sb%0d_%0d", tag, v, p));
            end
            compareVal($sformatf("%s_row%0d_score", tag, v), 32'(o_score_bcd), 32'(vecs[v].expScore));
            compareVal($sformatf("%s_row%0d_speed", tag, v), 32'(o_speed), 32'(vecs[v].expSpeed));
        end
    endtask

    task automatic sendTicks(input int n);
        for (int t = 0; t < n; t++) begin
            i_frame_tick = 1'b1;
            @(negedge clk);
            i_frame_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    // Press start for 'hold' cycles and count game_rst pulses over a fixed window
    task automatic pressStart(input string name, input int hold, input bit expectAccept);
        int nRst, firstIdx;
        nRst = 0;
        firstIdx = -1;
        i_btn_start = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == hold) i_btn_start = 1'b0;
            if (o_game_rst) begin
                nRst++;
                if (firstIdx < 0) firstIdx = k;
            end
        end
        i_btn_start = 1'b0;
        compareVal({name, "_rst_count"}, 32'(nRst), expectAccept ? 32'd1 : 32'd0);
        if (expectAccept) begin
            compareVal({name, "_rst_latency_ok"}, 32'((firstIdx >= 3) && (firstIdx <= 4)), 32'd1);
            modelPasses = 0;
        end
    endtask

    task automatic waitMode(input string name, input logic [1:0] target, input int budget);
        int k;
        k = 0;
        while ((o_mode !== target) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        compareVal(name, 32'(o_mode), 32'(target));
    endtask

    initial begin
        rst = 1'b1;
        i_btn_start = 1'b0;
        i_frame_tick = 1'b0;
        i_pass = 1'b0;
        i_collide = 1'b0;

        vecs.push_back('{5, 2, 8'h05, 4'd4});
        vecs.push_back('{4, 2, 8'h09, 4'd4});
        vecs.push_back('{5, 20, 8'h05, 4'd4});
        vecs.push_back('{5, 20, 8'h10, 4'd5});
        vecs.push_back('{2, 20, 8'h12, 4'd5});
        vecs.push_back('{8, 2, 8'h20, 4'd7});
        vecs.push_back('{79, 2, 8'h99, 4'd7});
        vecs.push_back('{1, 2, 8'h99, 4'd7});
        vecs.push_back('{20, 2, 8'h99, 4'd7});

        repeat (3) @(negedge clk);
        compareVal("reset_mode", 32'(o_mode), 32'd0);
        compareVal("reset_play_en", 32'(o_play_en), 32'd0);
        compareVal("reset_game_rst", 32'(o_game_rst), 32'd0);
        compareVal("reset_speed", 32'(o_speed), 32'd3);
        compareVal("reset_score", 32'(o_score_bcd), 32'h00);
        compareVal("reset_best", 32'(o_best_bcd), 32'h00);
        compareVal("reset_new_best", 32'(o_new_best), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] first round start");
        pressStart("start1", 5, 1'b1);
        compareVal("start1_mode", 32'(o_mode), 32'd1);
        compareVal("start1_play_en", 32'(o_play_en), 32'd1);
        compareVal("start1_speed", 32'(o_speed), 32'd3);
        compareVal("start1_score", 32'(o_score_bcd), 32'h00);

        pressStart("start_in_play", 3, 1'b0);
        compareVal("start_in_play_mode", 32'(o_mode), 32'd1);

        runVectors(0, 1, "r1");

        $display("[TB] pass and collide together at 09");
        i_pass = 1'b1;
        i_collide = 1'b1;
        @(negedge clk);
        compareVal("collide_mode", 32'(o_mode), 32'd2);
        compareVal("collide_score", 32'(o_score_bcd), 32'h09);
        compareVal("collide_play_en", 32'(o_play_en), 32'd0);
        i_pass = 1'b0;
        i_collide = 1'b0;
        repeat (2) @(negedge clk);
        sendTicks(59);
        compareVal("dying_after59_mode", 32'(o_mode), 32'd2);
        sendTicks(1);
        waitMode("over_mode", 2'd3, 4);
        compareVal("over_best", 32'(o_best_bcd), 32'h09);
        compareVal("over_new_best", 32'(o_new_best), 32'd1);

        $display("[TB] over lockout");
        sendTicks(10);
        pressStart("locked_start", 5, 1'b0);
        compareVal("locked_mode", 32'(o_mode), 32'd3);
        sendTicks(19);
        i_btn_start = 1'b1;
        repeat (2) @(negedge clk);
        i_frame_tick = 1'b1;
        @(negedge clk);
        i_frame_tick = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (o_game_rst) compareVal("tick_start_same_cycle_rst", 32'd1, 32'd0);
        end
        compareVal("tick_start_same_cycle_mode", 32'(o_mode), 32'd3);
        i_btn_start = 1'b0;
        repeat (3) @(negedge clk);
        pressStart("start2", 5, 1'b1);
        compareVal("start2_mode", 32'(o_mode), 32'd1);
        compareVal("start2_score", 32'(o_score_bcd), 32'h00);
        compareVal("start2_best", 32'(o_best_bcd), 32'h09);
        compareVal("start2_new_best", 32'(o_new_best), 32'd0);
        compareVal("start2_speed", 32'(o_speed), 32'd3);

        $display("[TB] second round pass bursts to saturation");
        runVectors(2, 8, "r2");

        $display("[TB] async reset during dying");
        i_collide = 1'b1;
        @(negedge clk);
        i_collide = 1'b0;
        compareVal("r2_collide_mode", 32'(o_mode), 32'd2);
        sendTicks(5);
        #2;
        rst = 1'b1;
        #1;
        compareVal("async_rst_mode", 32'(o_mode), 32'd0);
        compareVal("async_rst_play_en", 32'(o_play_en), 32'd0);
        compareVal("async_rst_game_rst", 32'(o_game_rst), 32'd0);
        compareVal("async_rst_speed", 32'(o_speed), 32'd3);
        compareVal("async_rst_score", 32'(o_score_bcd), 32'h00);
        compareVal("async_rst_best", 32'(o_best_bcd), 32'h00);
        compareVal("async_rst_new_best", 32'(o_new_best), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        pressStart("start3", 5, 1'b1);
        compareVal("start3_mode", 32'(o_mode), 32'd1);
        compareVal("start3_score", 32'(o_score_bcd), 32'h00);
        applyStimulus(2);
        checkOutput("r3_first_pass");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
